// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder built-in self-test engine.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    localparam int BIST_WIDTH = 4;
    localparam int IDX_W      = 2 * BIST_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

endpackage

// File: rtl/adder_bist_checker.sv
// Exhaustive self-test of a combinational adder: walks every operand pair,
// compares the sampled sum against an inline golden add, logs the first failure.
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = BIST_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_in0,
    output logic [WIDTH-1:0]     dut_in1,
    input  logic [WIDTH-1:0]     dut_out,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_in0,
    output logic [WIDTH-1:0]     fail_in1,
    output logic [WIDTH:0]       fail_sum
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  RELOAD  = CW'(SETTLE - 1);
    localparam logic [CW-1:0]  WAIT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]  LAST    = {IW{1'b1}};
    localparam logic [IW-1:0]  IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW:0]    ERR_ONE = {{IW{1'b0}}, 1'b1};

    bist_state_t     state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [CW-1:0]   wait_r, wait_s;
    logic [IW:0]     err_r, err_s;
    logic            fv_r, fv_s;
    logic [WIDTH-1:0] f0_r, f0_s, f1_r, f1_s;
    logic [WIDTH:0]  fs_r, fs_s;
    logic            busy_r, busy_s, done_r, done_s;
    logic [WIDTH:0]  golden_s, observed_s;

    // Next-state and datapath update for the test sequencer.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        wait_s     = wait_r;
        err_s      = err_r;
        fv_s       = fv_r;
        f0_s       = f0_r;
        f1_s       = f1_r;
        fs_s       = fs_r;
        busy_s     = busy_r;
        done_s     = done_r;
        golden_s   = {1'b0, idx_r[IW-1:WIDTH]} + {1'b0, idx_r[WIDTH-1:0]};
        observed_s = {dut_cout, dut_out};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_SETTLE;
                    idx_s   = {IW{1'b0}};
                    wait_s  = RELOAD;
                    err_s   = {(IW+1){1'b0}};
                    fv_s    = 1'b0;
                    f0_s    = {WIDTH{1'b0}};
                    f1_s    = {WIDTH{1'b0}};
                    fs_s    = {(WIDTH+1){1'b0}};
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (wait_r == {CW{1'b0}}) begin
                    state_s = ST_CHECK;
                end else begin
                    wait_s = wait_r - WAIT_ONE;
                end
            end
            ST_CHECK: begin
                if (observed_s != golden_s) begin
                    err_s = err_r + ERR_ONE;
                    // Only the first mismatching vector is kept for diagnosis.
                    if (!fv_r) begin
                        fv_s = 1'b1;
                        f0_s = idx_r[IW-1:WIDTH];
                        f1_s = idx_r[WIDTH-1:0];
                        fs_s = observed_s;
                    end else begin
                        fv_s = fv_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (idx_r == LAST) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SETTLE;
                    idx_s   = idx_r + IDX_ONE;
                    wait_s  = RELOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            wait_r  <= {CW{1'b0}};
            err_r   <= {(IW+1){1'b0}};
            fv_r    <= 1'b0;
            f0_r    <= {WIDTH{1'b0}};
            f1_r    <= {WIDTH{1'b0}};
            fs_r    <= {(WIDTH+1){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            wait_r  <= wait_s;
            err_r   <= err_s;
            fv_r    <= fv_s;
            f0_r    <= f0_s;
            f1_r    <= f1_s;
            fs_r    <= fs_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Operands come straight from the index register so the adder sees clean edges.
    assign dut_in0    = idx_r[IW-1:WIDTH];
    assign dut_in1    = idx_r[WIDTH-1:0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign err_count  = err_r;
    assign fail_valid = fv_r;
    assign fail_in0   = f0_r;
    assign fail_in1   = f1_r;
    assign fail_sum   = fs_r;
    assign pass       = done_r && (err_r == {(IW+1){1'b0}});

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench: a faultable adder model feeds the checker; expected run
// results and operand sequences are queued at start and consumed as the DUT runs.
module tb_adder_bist_checker;

    typedef struct {
        logic [8:0] err;
        logic       fv;
        logic [3:0] f0;
        logic [3:0] f1;
        logic [4:0] fs;
        logic       ps;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic b_start = 1'b0;
    int   fault = 0;

    logic [3:0] a_in0, a_in1, a_out, a_f0, a_f1;
    logic       a_cout, a_busy, a_done, a_pass, a_fv;
    logic [8:0] a_err;
    logic [4:0] a_fs;

    logic [3:0] b_in0, b_in1, b_out, b_f0, b_f1;
    logic       b_cout, b_busy, b_done, b_pass, b_fv;
    logic [8:0] b_err;
    logic [4:0] b_fs;

    int   checks = 0;
    int   fails = 0;
    res_t sb[$];
    logic [7:0] vq[$];

    always #5 clk = ~clk;

    function automatic logic [4:0] adder_model(logic [3:0] a, logic [3:0] b, int f);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (f == 1) s[0] = 1'b0;
        if (f == 2) s[4] = 1'b0;
        return s;
    endfunction

    always_comb {a_cout, a_out} = adder_model(a_in0, a_in1, fault);
    assign {b_cout, b_out} = {1'b0, b_in0} + {1'b0, b_in1};

    adder_bist_checker #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_in0(a_in0), .dut_in1(a_in1), .dut_out(a_out), .dut_cout(a_cout),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_valid(a_fv), .fail_in0(a_f0), .fail_in1(a_f1), .fail_sum(a_fs)
    );

    adder_bist_checker #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .dut_in0(b_in0), .dut_in1(b_in1), .dut_out(b_out), .dut_cout(b_cout),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .fail_valid(b_fv), .fail_in0(b_f0), .fail_in1(b_f1), .fail_sum(b_fs)
    );

    task automatic push_expected(int f);
        res_t r;
        logic [4:0] obs, gold;
        r.err = 9'd0; r.fv = 1'b0; r.f0 = 4'd0; r.f1 = 4'd0; r.fs = 5'd0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                obs  = adder_model(4'(a), 4'(b), f);
                gold = 5'(a + b);
                vq.push_back(8'(a * 16 + b));
                if (obs != gold) begin
                    r.err = r.err + 9'd1;
                    if (!r.fv) begin
                        r.fv = 1'b1; r.f0 = 4'(a); r.f1 = 4'(b); r.fs = obs;
                    end
                end
            end
        end
        r.ps = (r.err == 9'd0);
        sb.push_back(r);
    endtask

    task automatic run_a(string name, int f, int poke_at);
        int cycles;
        int h;
        res_t e;
        fault = f;
        vq.delete();
        push_expected(f);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if ({a_busy, a_done, a_err, a_fv} !== {1'b1, 1'b0, 9'd0, 1'b0}) begin
            fails++;
            $display("FAIL %s_start: busy/done/err/fv got %b expected %b", name,
                     {a_busy, a_done, a_err, a_fv}, {1'b1, 1'b0, 9'd0, 1'b0});
        end
        cycles = 0;
        h = 0;
        while (a_busy === 1'b1 && cycles < 600) begin
            checks++;
            if (vq.size() == 0) begin
                fails++;
                $display("FAIL %s_order: operands %h%h driven past last vector", name, a_in0, a_in1);
            end else if ({a_in0, a_in1} !== vq[0]) begin
                fails++;
                $display("FAIL %s_order: cycle %0d operands got %h expected %h", name, cycles, {a_in0, a_in1}, vq[0]);
            end
            h++;
            if (h == 2) begin
                if (vq.size() != 0) void'(vq.pop_front());
                h = 0;
            end
            start = (cycles == poke_at);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (cycles != 512) begin
            fails++;
            $display("FAIL %s_busy_len: got %0d expected 512", name, cycles);
        end
        checks++;
        if (a_done !== 1'b1 || vq.size() != 0) begin
            fails++;
            $display("FAIL %s_done: done got %b (vectors left %0d) expected 1 (0)", name, a_done, vq.size());
        end
        e = sb.pop_front();
        checks++;
        if (a_err !== e.err) begin
            fails++;
            $display("FAIL %s_err_count: got %0d expected %0d", name, a_err, e.err);
        end
        checks++;
        if (a_fv !== e.fv || a_pass !== e.ps) begin
            fails++;
            $display("FAIL %s_fv_pass: got %b%b expected %b%b", name, a_fv, a_pass, e.fv, e.ps);
        end
        if (e.fv) begin
            checks++;
            if ({a_f0, a_f1, a_fs} !== {e.f0, e.f1, e.fs}) begin
                fails++;
                $display("FAIL %s_first_fail: got %h/%h/%h expected %h/%h/%h", name,
                         a_f0, a_f1, a_fs, e.f0, e.f1, e.fs);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({a_in0, a_in1, a_busy, a_done, a_pass, a_err, a_fv, a_f0, a_f1, a_fs} !== 35'd0) begin
            fails++;
            $display("FAIL reset_a: outputs got %h expected 0",
                     {a_in0, a_in1, a_busy, a_done, a_pass, a_err, a_fv, a_f0, a_f1, a_fs});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({b_in0, b_in1, b_busy, b_done, b_pass, b_err, b_fv, b_f0, b_f1, b_fs} !== 35'd0) begin
            fails++;
            $display("FAIL reset_b_idle: outputs got %h expected 0",
                     {b_in0, b_in1, b_busy, b_done, b_pass, b_err, b_fv, b_f0, b_f1, b_fs});
        end
    endtask

    task automatic test_reset_mid_run();
        fault = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_err == 9'd0) begin
            fails++;
            $display("FAIL midrun_active: busy/err got %b/%0d expected 1/nonzero", a_busy, a_err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in0, a_in1, a_busy, a_done, a_pass, a_err, a_fv, a_f0, a_f1, a_fs} !== 35'd0) begin
            fails++;
            $display("FAIL midrun_reset: outputs got %h expected 0",
                     {a_in0, a_in1, a_busy, a_done, a_pass, a_err, a_fv, a_f0, a_f1, a_fs});
        end
        @(negedge clk) rst_n = 1'b1;
        run_a("after_reset", 0, -1);
    endtask

    task automatic test_settle3();
        int cycles;
        int h;
        res_t e;
        vq.delete();
        push_expected(0);
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cycles = 0;
        h = 0;
        while (b_busy === 1'b1 && cycles < 1100) begin
            checks++;
            if (vq.size() == 0 || {b_in0, b_in1} !== vq[0]) begin
                fails++;
                $display("FAIL settle3_hold: cycle %0d operands got %h expected %h", cycles,
                         {b_in0, b_in1}, (vq.size() != 0) ? vq[0] : 8'h00);
            end
            h++;
            if (h == 4) begin
                if (vq.size() != 0) void'(vq.pop_front());
                h = 0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != 1024) begin
            fails++;
            $display("FAIL settle3_busy_len: got %0d expected 1024", cycles);
        end
        e = sb.pop_front();
        checks++;
        if ({b_done, b_pass, b_err, b_fv} !== {1'b1, e.ps, e.err, e.fv}) begin
            fails++;
            $display("FAIL settle3_result: done/pass/err/fv got %b expected %b",
                     {b_done, b_pass, b_err, b_fv}, {1'b1, e.ps, e.err, e.fv});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        run_a("clean", 0, -1);
        run_a("out0_stuck", 1, -1);
        run_a("restart_from_done", 0, -1);
        run_a("cout_stuck", 2, -1);
        run_a("start_while_busy", 0, 50);
        test_reset_mid_run();
        test_settle3();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_bist_checker.md
# adder_bist_checker

Hardware self-test engine for the 4-bit combinational adder. It drives every operand pair into the adder and samples `out`/`cout` after a settle interval. Each sample is checked against an internal golden sum, with a mismatch count and the first failing vector recorded. It sits beside the adder instance and replaces simulation-only stimulus, so exhaustive checking also runs on silicon or FPGA.

## Interface
- `WIDTH`, 4: operand width of the adder under test.
- `SETTLE`, 1: cycles each vector is held before sampling; legal range is 1 or more.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- `dut_in0`  out  WIDTH  operand A driven to the adder.
- `dut_in1`  out  WIDTH  operand B driven to the adder.
- `dut_out`  in  WIDTH  adder sum.
- `dut_cout`  in  1  adder carry-out.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next `start` or reset.
- `pass`  out  1  `done` is high and `err_count` is 0.
- `err_count`  out  2*WIDTH+1  number of mismatching vectors.
- `fail_valid`  out  1  the `fail_*` outputs hold a captured vector.
- `fail_in0`, `fail_in1`  out  WIDTH  operands of the first mismatch.
- `fail_sum`  out  WIDTH+1  observed `{dut_cout, dut_out}` at the first mismatch.

## Operation
- **Vector index:** `idx` is a register of 2*WIDTH bits.
  - `dut_in0` is `idx[2W-1:W]` and `dut_in1` is `idx[W-1:0]`, both driven directly from the register with no glitching logic.
  - Order is in0-major and in1-minor: 0+0, 0+1, …, 0+F, 1+0, …, F+F.
- **States:** IDLE, SETTLE, CHECK, DONE.
  - IDLE → SETTLE on `start`. The same edge clears `idx`, `err_count`, `fail_*` and `fail_valid`, and loads the wait counter with SETTLE-1.
  - SETTLE: holds for SETTLE cycles, counting down to 0, then → CHECK.
  - CHECK: compares `{dut_cout, dut_out}` against the zero-extended sum `dut_in0 + dut_in1`, computed at WIDTH+1 bits.
    - On a mismatch, `err_count` increments. If `fail_valid` is 0, the vector is captured and `fail_valid` is set.
    - If `idx` is all-ones → DONE; otherwise `idx` increments, the wait counter reloads, and the state → SETTLE.
  - DONE: on `start`, the same clearing as IDLE, then → SETTLE.
- **`start` while busy:** ignored, with no effect on the run.
- **`err_count` width:** holds up to 2^(2W) exactly, so no saturation is required.
- **Reset mid-run:** all state returns to reset values immediately, with no partial result retained.

## Timing
- **Reset values:** state is IDLE and all outputs are 0, including `dut_in0`/`dut_in1`, `busy`, `done`, `pass`, `err_count`, `fail_*` and `fail_valid`.
- **`busy`:** rises the cycle after `start` is sampled. It stays high for exactly 2^(2W)·(SETTLE+1) cycles, which is 512 at the defaults.
- **`done`:** rises the cycle after the last CHECK, in the same cycle `busy` falls.
- **Sampling:** `dut_out`/`dut_cout` are sampled at the clock edge ending CHECK. The adder therefore has SETTLE+1 full cycles of propagation.
- **`pass`:** combinational from `done` and `err_count`, and valid whenever `done` is high.

## Structure
- **Package `adder_bist_pkg`:** holds the state enum `bist_state_t`, a localparam for the index width (2*WIDTH), and the last-index constant.
- **No sub-module.** The golden adder is a single inline `+` expression. The adder under test is instantiated outside this block.

## Test plan
- **Correct ripple-carry adder, defaults:** pulse `start` → `busy` is high for 512 cycles, then `done`=1, `pass`=1, `err_count`=0 and `fail_valid`=0.
- **Fault `dut_out[0]` stuck-at-0:**
  - `err_count`=128.
  - First failure is `fail_in0`=0, `fail_in1`=1, `fail_sum`=0.
  - `pass`=0.
- **Fault `dut_cout` stuck-at-0:**
  - `err_count`=120.
  - First failure is `fail_in0`=1, `fail_in1`=F, `fail_sum`=0_0000.
- **Reset mid-run:** deassert `rst_n` 100 cycles after `start` → all outputs are 0 immediately. A later `start` completes a full clean 512-cycle run.
- **`start` behaviour:**
  - Pulse `start` at cycle 50 of a run → no restart, and `done` still arrives at cycle 512.
  - `start` in DONE after a faulty run, with the fault removed → `err_count` and `fail_valid` clear and the run ends with `pass`=1.
- **`SETTLE`=3, correct adder:** `busy` lasts 1024 cycles, and each vector is held 4 cycles on `dut_in0`/`dut_in1`.
